// File: rtl/pipeline_controller_if.sv
// Control/status bundle between the pipeline controller and the IF/ID/EX stages.
// The controller uses the slave side and the core-side logic (or a bench) uses the master side.
interface pipeline_controller_if #(
  parameter int CNT_W = 32
);
  logic             run_mode;
  logic             step_req;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             branch_taken;
  logic             halt_instr;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             step_done;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output run_mode, step_req, id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, halt_instr,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, step_done, halted, cycle_count
  );

  modport slave (
    input  run_mode, step_req, id_rs, id_rt, ex_mem_read, ex_rt, branch_taken, halt_instr,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, step_done, halted, cycle_count
  );
endinterface

// File: rtl/pipeline_controller.sv
// Sequencer for the IF/ID/EX pipeline of the MIPS_DLX core. It handles load-use stalls,
// taken-branch flushes, single-step debug and the drain that follows a halt.
module pipeline_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic            clock,
  input logic            reset,
  pipeline_controller_if.slave bus
);

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
  logic             step_done_q, step_done_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic load_use_s;
  logic active_s;
  logic pc_write_s;
  logic if_id_write_s;
  logic id_ex_bubble_s;
  logic if_id_flush_s;
  logic halted_s;

  // A register number of zero never creates a dependency.
  function automatic logic f_load_use(input logic       mem_read,
                                      input logic [4:0] dst,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt);
    return mem_read && (dst != 5'd0) && ((dst == rs) || (dst == rt));
  endfunction

  assign load_use_s = f_load_use(bus.ex_mem_read, bus.ex_rt, bus.id_rs, bus.id_rt);
  assign active_s   = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);

  // State, drain counter, step pulse and active-cycle counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_STOP;
      drain_cnt_q   <= '0;
      step_done_q   <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      step_done_q   <= step_done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: begin
        if (bus.run_mode) begin
          state_d = ST_RUN;
        end else if (bus.step_req) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_RUN: begin
        // A load-use stall masks the halt, so the HALT is taken again once the stall clears.
        if (!load_use_s && bus.halt_instr) begin
          state_d = ST_DRAIN;
        end else if (bus.run_mode) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_STEP: begin
        if (!load_use_s && bus.halt_instr) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_STOP;
    endcase
  end

  // Drain counter, step-done pulse and saturating active-cycle counter
  always_comb begin
    drain_cnt_d   = '0;
    step_done_d   = 1'b0;
    cycle_count_d = cycle_count_q;
    if (state_q == ST_DRAIN) begin
      drain_cnt_d = drain_cnt_q + DW'(1);
    end else begin
      drain_cnt_d = '0;
    end
    if (state_q == ST_STEP) begin
      step_done_d = 1'b1;
    end else begin
      step_done_d = 1'b0;
    end
    if (active_s && (cycle_count_q != {CNT_W{1'b1}})) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end else begin
      cycle_count_d = cycle_count_q;
    end
  end

  // Pipeline enables decoded from the current state and hazard inputs
  always_comb begin
    pc_write_s     = 1'b0;
    if_id_write_s  = 1'b0;
    id_ex_bubble_s = 1'b0;
    if_id_flush_s  = 1'b0;
    halted_s       = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP: begin
        if (load_use_s) begin
          id_ex_bubble_s = 1'b1;
        end else if (bus.halt_instr) begin
          id_ex_bubble_s = 1'b1;
        end else if (bus.branch_taken) begin
          pc_write_s     = 1'b1;
          if_id_write_s  = 1'b1;
          if_id_flush_s  = 1'b1;
        end else begin
          pc_write_s     = 1'b1;
          if_id_write_s  = 1'b1;
        end
      end
      ST_DRAIN:  id_ex_bubble_s = 1'b1;
      ST_HALTED: halted_s       = 1'b1;
      default: begin
        pc_write_s     = 1'b0;
        if_id_write_s  = 1'b0;
        id_ex_bubble_s = 1'b0;
        if_id_flush_s  = 1'b0;
        halted_s       = 1'b0;
      end
    endcase
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.if_id_write  = if_id_write_s;
  assign bus.id_ex_bubble = id_ex_bubble_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.halted       = halted_s;
  assign bus.step_done    = step_done_q;
  assign bus.cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller: the stimulus process queues hand-computed
// expectations, and the monitor pops and compares them on every falling edge.
module tb_pipeline_controller;

  localparam int CNT_W = 32;

  logic clock;
  logic reset;

  pipeline_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_controller #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [5:0]  ctl;  // {pc_write, if_id_write, id_ex_bubble, if_id_flush, step_done, halted}
    int unsigned cc;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: compare whatever the DUT presents against the oldest queued expectation
  initial begin
    exp_t       e;
    logic [5:0] act;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {bus.pc_write, bus.if_id_write, bus.id_ex_bubble, bus.if_id_flush,
               bus.step_done, bus.halted};
        n_checks++;
        if (act !== e.ctl) begin
          n_fails++;
          $display("FAIL %s ctl: got %b, expected %b (pc,ifid,bub,flush,sdone,halted)",
                   e.nm, act, e.ctl);
        end
        n_checks++;
        if (bus.cycle_count !== CNT_W'(e.cc)) begin
          n_fails++;
          $display("FAIL %s cycle_count: got %0d, expected %0d", e.nm, bus.cycle_count, e.cc);
        end
      end
    end
  end

  // One cycle: drive inputs just after the rising edge and queue the expected outputs
  task automatic cyc(input logic rst, input logic rm, input logic sr, input logic mr,
                     input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                     input logic br, input logic hl, input logic [5:0] ectl,
                     input int unsigned ecc, input string nm);
    exp_t e;
    reset            = rst;
    bus.run_mode     = rm;
    bus.step_req     = sr;
    bus.ex_mem_read  = mr;
    bus.ex_rt        = ert;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.branch_taken = br;
    bus.halt_instr   = hl;
    e.ctl = ectl;
    e.cc  = ecc;
    e.nm  = nm;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    bus.run_mode     = 1'b0;
    bus.step_req     = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.ex_rt        = 5'd0;
    bus.id_rs        = 5'd0;
    bus.id_rt        = 5'd0;
    bus.branch_taken = 1'b0;
    bus.halt_instr   = 1'b0;
    @(posedge clock);
    #1;

    // Reset and STOP
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 0, "reset");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 0, "stop_idle");

    // T1: free run, no hazards
    for (int i = 0; i < 10; i++)
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b110000, i, "t1_run");

    // T2: load-use stalls and non-stalls
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 6'b001000, 10, "t2_rs_match");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b110000, 11, "t2_after");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b110000, 12, "t2_rt_zero");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 6'b001000, 13, "t2_rt_match");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 6'b110000, 14, "t2_no_load");

    // T3: stall beats branch, then branch flushes; run_mode drop still advances
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 6'b001000, 15, "t3_stall_br");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 6'b110100, 16, "t3_branch");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b110000, 17, "run_exit");

    // T4: single-step with three requests four cycles apart
    for (int j = 0; j < 2; j++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 18 + j, "t4_req");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b110000, 18 + j, "t4_step");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000010, 19 + j, "t4_done");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 19 + j, "t4_idle");
    end
    // Third step is stalled by a load-use; the step_req seen during STEP is ignored
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 20, "t4_req3");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 6'b001000, 20, "t4_step_stall");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000010, 21, "t4_done3");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 21, "t4_no_queue");

    // run_mode has priority over step_req in STOP
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 21, "prio_stop");

    // T5: halt, three drain cycles, then HALTED holds
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'b001000, 21, "t5_halt");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 6'b001000, 22, "t5_drain0");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b001000, 23, "t5_drain1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b001000, 24, "t5_drain2");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 6'b000001, 25, "t5_halted");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000001, 25, "t5_halted_hold");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000001, 25, "t5_halted_hold2");

    // T6: reset in the middle of a drain
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 0, "t6_reset_halted");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 0, "t6_stop");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 6'b001000, 0, "t6_halt");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b001000, 1, "t6_drain0");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 0, "t6_reset_drain");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000000, 0, "t6_after_stop");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b110000, 0, "t6_step");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b000010, 1, "t6_step_done");

    @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain_queue: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
